// File: rtl/mem_pipelined.sv
// mem_pipelined: dual-port byte-addressable memory with a fixed RD_LATENCY response
// pipeline on each port. Port I fetches 32-bit words; port D does RV32 loads/stores.
// A CLEAR state machine zeroes the array one word per cycle.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses report an
// error (D) or return 32'hDEAD_BEEF (I) instead of being performed bytewise.
`ifndef MEM_DEPTH
`define MEM_DEPTH 256
`endif

module mem_pipelined #(
    parameter int                AWIDTH     = 32,
    parameter int                DWIDTH     = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR  = 32'h0100_0000,
    parameter int                MEM_BYTES  = `MEM_DEPTH,
    parameter int                RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_i,
    input  logic [AWIDTH-1:0] i_addr_i,
    output logic              i_ready_o,
    output logic              i_vld_o,
    output logic [DWIDTH-1:0] i_data_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [2:0]        d_funct3_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_ready_o,
    output logic              d_vld_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic              d_err_o,
    input  logic              clear_i,
    output logic              busy_o
);
    localparam int IW   = $clog2(MEM_BYTES);
    localparam int CW   = $clog2(MEM_BYTES / 4);
    localparam int LAST = MEM_BYTES / 4 - 1;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [7:0]        r_mem [MEM_BYTES];

    logic              r_i_vld_p  [RD_LATENCY];
    logic [31:0]       r_i_data_p [RD_LATENCY];
    logic              r_d_vld_p  [RD_LATENCY];
    logic [31:0]       r_d_data_p [RD_LATENCY];
    logic              r_d_err_p  [RD_LATENCY];

    logic              w_ready, w_i_acc, w_d_acc, w_i_err, w_d_err, w_d_wr, w_f3_bad;
    logic [AWIDTH-1:0] w_i_off, w_d_off;
    logic [2:0]        w_d_size;
    logic [7:0]        w_i_b [4];
    logic [7:0]        w_d_b [4];
    logic [31:0]       w_i_word, w_d_result;

    // Byte read that returns 0 for offsets past the end of the array.
    function automatic logic [7:0] rd_byte(input logic [AWIDTH-1:0] off);
        if (off < AWIDTH'(MEM_BYTES)) return r_mem[IW'(off)];
        return 8'h00;
    endfunction

    // True when every byte of [a, a+sz-1] is mapped; computed one bit wider so it cannot wrap.
    function automatic logic in_rng(input logic [AWIDTH-1:0] a, input logic [2:0] sz);
        logic [AWIDTH:0] lo, hi, base_x;
        lo     = {1'b0, a};
        hi     = lo + (AWIDTH+1)'(sz) - (AWIDTH+1)'(1);
        base_x = {1'b0, BASE_ADDR};
        return (lo >= base_x) && (hi < base_x + (AWIDTH+1)'(MEM_BYTES));
    endfunction

    // Simulation-only unknown check; constant 0 in hardware.
    function automatic logic has_x(input logic [AWIDTH-1:0] a);
        return ((^a) === 1'bx);
    endfunction

    // RV32 load extension of the little-endian word starting at the access address.
    function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign w_ready   = (r_state == S_IDLE) & ~rst;
    assign w_i_acc   = i_req_i & w_ready;
    assign w_d_acc   = d_req_i & w_ready;
    assign w_i_off   = i_addr_i - BASE_ADDR;
    assign w_d_off   = d_addr_i - BASE_ADDR;
    assign w_d_size  = (d_funct3_i[1:0] == 2'b00) ? 3'd1 : (d_funct3_i[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign w_f3_bad  = d_we_i ? (d_funct3_i > 3'b010)
                              : (d_funct3_i == 3'b011 || d_funct3_i[2:1] == 2'b11);

    // Decode both ports: gather bytes, range/funct3/alignment checks, result words.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_i_b[k] = rd_byte(w_i_off + AWIDTH'(k));
            w_d_b[k] = rd_byte(w_d_off + AWIDTH'(k));
        end
        w_i_err = ~in_rng(i_addr_i, 3'd4) | has_x(i_addr_i);
        w_d_err = w_f3_bad | ~in_rng(d_addr_i, w_d_size) | has_x(d_addr_i);
`ifdef MEM_MISALIGN_TRAP_EN
        if (i_addr_i[1:0] != 2'b00) w_i_err = 1'b1;
        if ((w_d_size == 3'd2 && d_addr_i[0]) || (w_d_size == 3'd4 && d_addr_i[1:0] != 2'b00))
            w_d_err = 1'b1;
`endif
        w_i_word   = w_i_err ? 32'hDEAD_BEEF : {w_i_b[3], w_i_b[2], w_i_b[1], w_i_b[0]};
        w_d_result = (d_we_i | w_d_err) ? 32'h0
                   : ld_ext(d_funct3_i, {w_d_b[3], w_d_b[2], w_d_b[1], w_d_b[0]});
        w_d_wr     = w_d_acc & d_we_i & ~w_d_err;
    end

    // CLEAR state and word counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: start on clear_i in IDLE, return after the last word.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clear_i) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (r_cnt == CW'(LAST)) w_state_nxt = S_IDLE;
                else                    w_cnt_nxt   = r_cnt + CW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Array writes: clear word while in CLEAR, otherwise accepted stores (states are exclusive).
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR && !rst) begin
            for (int k = 0; k < 4; k++) r_mem[IW'({r_cnt, 2'(k)})] <= 8'h00;
        end else if (w_d_wr) begin
            for (int k = 0; k < 4; k++)
                if (3'(k) < w_d_size) r_mem[IW'(w_d_off + AWIDTH'(k))] <= d_wdata_i[8*k +: 8];
        end
    end

    // Response valid pipes: loaded at accept, flushed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_i_vld_p[k] <= 1'b0;
                r_d_vld_p[k] <= 1'b0;
            end
        end else begin
            for (int k = RD_LATENCY - 1; k > 0; k--) begin
                r_i_vld_p[k] <= r_i_vld_p[k-1];
                r_d_vld_p[k] <= r_d_vld_p[k-1];
            end
            r_i_vld_p[0] <= w_i_acc;
            r_d_vld_p[0] <= w_d_acc;
        end
    end

    // Response data pipes: sampled at the accept edge, then shifted.
    always_ff @(posedge clk) begin
        for (int k = RD_LATENCY - 1; k > 0; k--) begin
            r_i_data_p[k] <= r_i_data_p[k-1];
            r_d_data_p[k] <= r_d_data_p[k-1];
            r_d_err_p[k]  <= r_d_err_p[k-1];
        end
        r_i_data_p[0] <= w_i_word;
        r_d_data_p[0] <= w_d_result;
        r_d_err_p[0]  <= w_d_err;
    end

    assign i_ready_o = w_ready;
    assign d_ready_o = w_ready;
    assign busy_o    = (r_state == S_CLEAR) & ~rst;
    assign i_vld_o   = r_i_vld_p[RD_LATENCY-1] & ~rst;
    assign d_vld_o   = r_d_vld_p[RD_LATENCY-1] & ~rst;
    assign i_data_o  = i_vld_o ? r_i_data_p[RD_LATENCY-1] : '0;
    assign d_rdata_o = d_vld_o ? r_d_data_p[RD_LATENCY-1] : '0;
    assign d_err_o   = d_vld_o & r_d_err_p[RD_LATENCY-1];
endmodule

// File: tb/tb_mem_pipelined.sv
// Testbench for mem_pipelined: directed vector table, clear/reset sequences and a random
// phase, all checked cycle by cycle against a byte-array reference model with response queues.
module tb_mem_pipelined;
    localparam int          LAT  = 2;
    localparam int          MB   = 256;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 0, rst = 1;
    logic        i_req_i = 0, d_req_i = 0, d_we_i = 0, clear_i = 0;
    logic [31:0] i_addr_i = BASE, d_addr_i = BASE, d_wdata_i = 0;
    logic [2:0]  d_funct3_i = 0;
    logic        i_ready_o, i_vld_o, d_ready_o, d_vld_o, d_err_o, busy_o;
    logic [31:0] i_data_o, d_rdata_o;

    mem_pipelined #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .MEM_BYTES(MB), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ready_o(i_ready_o), .i_vld_o(i_vld_o), .i_data_o(i_data_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_funct3_i(d_funct3_i), .d_wdata_i(d_wdata_i),
        .d_ready_o(d_ready_o), .d_vld_o(d_vld_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .clear_i(clear_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] data; logic err; } rsp_t;
    typedef struct { bit we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd; logic [31:0] exp_d; bit exp_e; } vec_t;

    rsp_t        qi[$], qd[$];
    logic [7:0]  ref_mem [MB];
    bit          m_busy = 0;
    int          m_cnt = 0, cyc = 0, checks = 0, errors = 0;
    logic [31:0] last_d; logic last_e; bit seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a, input int sz);
        longint la = longint'(a);
        return la >= longint'(BASE) && la + sz <= longint'(BASE) + MB;
    endfunction

    function automatic logic [31:0] model_fetch(input logic [31:0] a);
        int off = int'(longint'(a) - longint'(BASE));
        logic [31:0] v = 0;
        if (!in_range(a, 4)) return 32'hDEAD_BEEF;
`ifdef MEM_MISALIGN_TRAP_EN
        if (a % 4 != 0) return 32'hDEAD_BEEF;
`endif
        for (int i = 0; i < 4; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
        return v;
    endfunction

    task automatic model_d(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er);
        int sz = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        int off = int'(longint'(a) - longint'(BASE));
        logic [31:0] v = 0;
        bit bad = we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7);
        if (!in_range(a, sz)) bad = 1;
`ifdef MEM_MISALIGN_TRAP_EN
        if (a % sz != 0) bad = 1;
`endif
        rd = 0; er = bad;
        if (bad) return;
        if (we) begin
            for (int i = 0; i < sz; i++) ref_mem[off + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
            if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
        end
    endtask

    // One clock: model the accepts from the current inputs, clock, then check every output.
    task automatic step();
        bit   rdy = !m_busy && !rst;
        bit   ai = i_req_i && rdy, ad = d_req_i && rdy, ev;
        rsp_t ri, rd;
        if (ai) ri = '{0, model_fetch(i_addr_i), 1'b0};
        if (ad) model_d(d_we_i, d_funct3_i, d_addr_i, d_wdata_i, rd.data, rd.err);
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_busy = 0; qi.delete(); qd.delete();
        end else begin
            if (m_busy) begin
                for (int k = 0; k < 4; k++) ref_mem[4*m_cnt + k] = 8'h00;
                m_cnt++;
                if (m_cnt == MB / 4) m_busy = 0;
            end else if (clear_i) begin
                m_busy = 1; m_cnt = 0;
            end
            if (ai) begin ri.due = cyc + LAT - 1; qi.push_back(ri); end
            if (ad) begin rd.due = cyc + LAT - 1; qd.push_back(rd); end
        end
        #1;
        chk("busy", 32'(busy_o), 32'(m_busy && !rst));
        chk("i_ready", 32'(i_ready_o), 32'(!m_busy && !rst));
        chk("d_ready", 32'(d_ready_o), 32'(!m_busy && !rst));
        ev = qi.size() > 0 && qi[0].due == cyc;
        chk("i_vld", 32'(i_vld_o), 32'(ev));
        if (ev) begin chk("i_data", i_data_o, qi[0].data); void'(qi.pop_front()); end
        ev = qd.size() > 0 && qd[0].due == cyc;
        chk("d_vld", 32'(d_vld_o), 32'(ev));
        if (ev) begin
            chk("d_rdata", d_rdata_o, qd[0].data);
            chk("d_err", 32'(d_err_o), 32'(qd[0].err));
            void'(qd.pop_front());
        end
        if (d_vld_o) begin last_d = d_rdata_o; last_e = d_err_o; seen = 1; end
    endtask

    task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        seen = 0;
        d_we_i = we; d_funct3_i = f3; d_addr_i = a; d_wdata_i = wd; d_req_i = 1;
        step();
        d_req_i = 0;
        repeat (LAT + 1) step();
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_D = 32'h0; localparam bit MIS_E = 1;
`else
    localparam logic [31:0] MIS_D = 32'h7788_1122; localparam bit MIS_E = 0;
`endif

    vec_t tv[16];
    int   nb;

    initial begin
        tv[0]  = '{1, 3'b010, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0, 0};
        tv[1]  = '{0, 3'b010, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF, 0};
        tv[2]  = '{1, 3'b000, BASE + 32'h20, 32'h0000_0080, 32'h0, 0};
        tv[3]  = '{0, 3'b000, BASE + 32'h20, 32'h0, 32'hFFFF_FF80, 0};
        tv[4]  = '{0, 3'b100, BASE + 32'h20, 32'h0, 32'h0000_0080, 0};
        tv[5]  = '{0, 3'b001, BASE + 32'h20, 32'h0, 32'h0000_0080, 0};
        tv[6]  = '{0, 3'b010, 32'h00FF_FFFC, 32'h0, 32'h0, 1};
        tv[7]  = '{0, 3'b010, BASE + MB - 2, 32'h0, 32'h0, 1};
        tv[8]  = '{1, 3'b011, BASE + 32'h10, 32'h0, 32'h0, 1};
        tv[9]  = '{0, 3'b010, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF, 0};
        tv[10] = '{0, 3'b010, 32'hFFFF_FFFF, 32'h0, 32'h0, 1};
        tv[11] = '{1, 3'b010, BASE, 32'h1122_3344, 32'h0, 0};
        tv[12] = '{1, 3'b010, BASE + 4, 32'h5566_7788, 32'h0, 0};
        tv[13] = '{0, 3'b010, BASE + 2, 32'h0, MIS_D, MIS_E};
        tv[14] = '{0, 3'b001, BASE + MB - 1, 32'h0, 32'h0, 1};
        tv[15] = '{0, 3'b110, BASE + 32'h20, 32'h0, 32'h0, 1};
        for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;

        // Reset: outputs quiet, not ready.
        repeat (2) step();
        rst = 0;
        step();
        // Initial clear so array contents are known.
        clear_i = 1; step(); clear_i = 0;
        repeat (MB / 4 + 2) step();

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            do_op(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd);
            chk($sformatf("tbl%0d_seen", i), 32'(seen), 32'd1);
            chk($sformatf("tbl%0d_rdata", i), last_d, tv[i].exp_d);
            chk($sformatf("tbl%0d_err", i), 32'(last_e), 32'(tv[i].exp_e));
        end

        // Store then load on the next cycle, then 4 back-to-back loads with a fetch stream.
        d_req_i = 1; d_we_i = 1; d_funct3_i = 3'b010; d_addr_i = BASE + 32'h40; d_wdata_i = 32'hCAFE_F00D;
        i_req_i = 1; i_addr_i = BASE + 32'h40;
        step();
        d_we_i = 0;
        for (int k = 0; k < 4; k++) begin
            d_addr_i = BASE + 32'h40 - 32'(4 * k);
            i_addr_i = BASE + 32'(4 * k);
            step();
        end
        d_req_i = 0; i_req_i = 0;
        repeat (LAT + 1) step();

        // Clear with a pending store held off by ready; busy length counted.
        do_op(1, 3'b010, BASE, 32'h1234_5678);
        clear_i = 1; step(); clear_i = 0;
        nb = 1;
        d_req_i = 1; d_we_i = 1; d_funct3_i = 3'b010; d_addr_i = BASE + 8; d_wdata_i = 32'hFFFF_FFFF;
        for (int k = 0; k < 200 && busy_o; k++) begin
            step();
            if (busy_o) nb++;
        end
        d_req_i = 0;
        chk("busy_len", 32'(nb), 32'(MB / 4));
        step();
        do_op(0, 3'b010, BASE, 32'h0);
        chk("clr_ld", last_d, 32'h0);

        // Reset in the middle of a clear: words written afterwards keep their data.
        do_op(1, 3'b010, BASE + MB - 4, 32'hA5A5_5A5A);
        clear_i = 1; step(); clear_i = 0;
        repeat (10) step();
        rst = 1; step(); rst = 0;
        step();
        chk("busy_after_rst", 32'(busy_o), 32'd0);
        do_op(0, 3'b010, BASE + MB - 4, 32'h0);
        chk("partial_clr", last_d, 32'hA5A5_5A5A);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            i_req_i    = 1'($urandom_range(0, 1));
            i_addr_i   = BASE - 4 + $urandom_range(0, MB + 7);
            d_req_i    = 1'($urandom_range(0, 1));
            d_we_i     = 1'($urandom_range(0, 1));
            d_funct3_i = 3'($urandom_range(0, 7));
            d_addr_i   = BASE - 4 + $urandom_range(0, MB + 7);
            d_wdata_i  = $urandom;
            clear_i    = ($urandom_range(0, 299) == 0);
            step();
        end
        i_req_i = 0; d_req_i = 0; clear_i = 0;
        repeat (MB / 4 + LAT + 2) step();
        chk("i_drained", 32'(qi.size()), 32'd0);
        chk("d_drained", 32'(qd.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
